// File: rtl/adc_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : adc_scanner (with private adc_scanner_uart_tx / adc_scanner_uart_rx)
//  Purpose  : Round-robin ADC channel poller over a UART link, with enable
//             mask, response timeout, per-channel valid flags and sample strobe.
//  Revision : 1.0  initial release
// ============================================================================

module adc_scanner_uart_tx #(
    parameter int TICKS_PER_CYCLE = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic [7:0] i_data,
    output logic       o_done,
    output logic       o_tx
);
    localparam int c_tick_w = (TICKS_PER_CYCLE > 1) ? $clog2(TICKS_PER_CYCLE) : 1;
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICKS_PER_CYCLE - 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SHIFT = 2'd1,
        TX_DONE  = 2'd2
    } tx_state_t;

    tx_state_t             r_state_q, w_state_d;
    logic [9:0]            r_shift_q, w_shift_d;
    logic [3:0]            r_bit_q,   w_bit_d;
    logic [c_tick_w-1:0]   r_tick_q,  w_tick_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= TX_IDLE;
            r_shift_q <= '1;
            r_bit_q   <= '0;
            r_tick_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_shift_q <= w_shift_d;
            r_bit_q   <= w_bit_d;
            r_tick_q  <= w_tick_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_shift_d = r_shift_q;
        w_bit_d   = r_bit_q;
        w_tick_d  = r_tick_q;
        case (r_state_q)
            TX_IDLE: begin
                if (i_req) begin
                    w_shift_d = {1'b1, i_data, 1'b0};
                    w_bit_d   = '0;
                    w_tick_d  = '0;
                    w_state_d = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (r_tick_q == c_tick_last) begin
                    w_tick_d = '0;
                    if (r_bit_q == 4'd9) begin
                        w_state_d = TX_DONE;
                    end else begin
                        w_shift_d = {1'b1, r_shift_q[9:1]};
                        w_bit_d   = r_bit_q + 1'b1;
                    end
                end else begin
                    w_tick_d = r_tick_q + 1'b1;
                end
            end
            TX_DONE: begin
                // Completion is held until the requester lets go.
                if (!i_req) w_state_d = TX_IDLE;
            end
            default: w_state_d = TX_IDLE;
        endcase
    end

    assign o_done = (r_state_q == TX_DONE);
    assign o_tx   = (r_state_q == TX_SHIFT) ? r_shift_q[0] : 1'b1;
endmodule

module adc_scanner_uart_rx #(
    parameter int TICKS_PER_CYCLE = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ready,
    input  logic       i_rx,
    output logic       o_done,
    output logic [7:0] o_data
);
    localparam int c_tick_w = (TICKS_PER_CYCLE > 1) ? $clog2(TICKS_PER_CYCLE) : 1;
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICKS_PER_CYCLE - 1);
    localparam logic [c_tick_w-1:0] c_tick_half =
        c_tick_w'((TICKS_PER_CYCLE / 2 > 0) ? (TICKS_PER_CYCLE / 2 - 1) : 0);

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_DONE  = 3'd4
    } rx_state_t;

    rx_state_t             r_state_q, w_state_d;
    logic [1:0]            r_sync_q,  w_sync_d;
    logic [7:0]            r_shift_q, w_shift_d;
    logic [2:0]            r_bit_q,   w_bit_d;
    logic [c_tick_w-1:0]   r_tick_q,  w_tick_d;
    logic                  w_rx;

    assign w_sync_d = {r_sync_q[0], i_rx};
    assign w_rx     = r_sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= RX_IDLE;
            r_sync_q  <= 2'b11;
            r_shift_q <= '0;
            r_bit_q   <= '0;
            r_tick_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_sync_q  <= w_sync_d;
            r_shift_q <= w_shift_d;
            r_bit_q   <= w_bit_d;
            r_tick_q  <= w_tick_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_shift_d = r_shift_q;
        w_bit_d   = r_bit_q;
        w_tick_d  = r_tick_q;
        // Dropping ready discards any frame in progress.
        if (!i_ready) begin
            w_state_d = RX_IDLE;
        end else begin
            case (r_state_q)
                RX_IDLE: begin
                    if (!w_rx) begin
                        w_tick_d  = '0;
                        w_state_d = RX_START;
                    end
                end
                RX_START: begin
                    if (r_tick_q == c_tick_half) begin
                        w_tick_d  = '0;
                        w_bit_d   = '0;
                        w_state_d = w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        w_tick_d = r_tick_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_tick_q == c_tick_last) begin
                        w_tick_d  = '0;
                        w_shift_d = {w_rx, r_shift_q[7:1]};
                        if (r_bit_q == 3'd7) w_state_d = RX_STOP;
                        else                 w_bit_d   = r_bit_q + 1'b1;
                    end else begin
                        w_tick_d = r_tick_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_tick_q == c_tick_last) begin
                        w_tick_d  = '0;
                        w_state_d = w_rx ? RX_DONE : RX_IDLE;
                    end else begin
                        w_tick_d = r_tick_q + 1'b1;
                    end
                end
                RX_DONE:  w_state_d = RX_DONE;
                default:  w_state_d = RX_IDLE;
            endcase
        end
    end

    assign o_done = (r_state_q == RX_DONE);
    assign o_data = r_shift_q;
endmodule

module adc_scanner #(
    parameter int         CHANNELS        = 4,
    parameter int         TICKS_PER_CYCLE = 48,
    parameter logic [7:0] BASE_CMD        = 8'hA1,
    parameter int         TIMEOUT_CYCLES  = 24000,
    parameter int         IDX_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clock12MHz,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [CHANNELS-1:0]     channelMask,
    input  logic                    serialIn,
    output logic                    serialOut,
    output logic [10*CHANNELS-1:0]  values,
    output logic [CHANNELS-1:0]     valid,
    output logic                    sampleStrobe,
    output logic [IDX_W-1:0]        sampleChannel,
    output logic                    timeoutError,
    output logic [7:0]              timeoutCount
);
    localparam int c_timer_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]     c_idx_last   = IDX_W'(CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SELECT    = 3'd1,
        S_SEND_WAIT = 3'd2,
        S_SEND      = 3'd3,
        S_RECV_LO   = 3'd4,
        S_GAP       = 3'd5,
        S_RECV_HI   = 3'd6,
        S_COMMIT    = 3'd7
    } state_t;

    state_t                   r_state_q,  w_state_d;
    logic [IDX_W-1:0]         r_ptr_q,    w_ptr_d;
    logic [IDX_W-1:0]         r_idx_q,    w_idx_d;
    logic                     r_send_req_q, w_send_req_d;
    logic                     r_ready_q,  w_ready_d;
    logic [c_timer_w-1:0]     r_timer_q,  w_timer_d;
    logic [7:0]               r_lo_q,     w_lo_d;
    logic [10*CHANNELS-1:0]   r_values_q, w_values_d;
    logic [CHANNELS-1:0]      r_valid_q,  w_valid_d;
    logic                     r_strobe_q, w_strobe_d;
    logic [IDX_W-1:0]         r_chan_q,   w_chan_d;
    logic                     r_terr_q,   w_terr_d;
    logic [7:0]               r_tcount_q, w_tcount_d;

    logic                     w_tx_done;
    logic                     w_rx_done;
    logic [7:0]               w_rx_data;
    logic [7:0]               w_send_data;
    logic [2*CHANNELS-1:0]    w_mask2;
    logic [CHANNELS-1:0]      w_rot;
    logic                     w_sel_found;
    int                       w_sel_sum;
    logic [IDX_W-1:0]         w_sel_idx;
    logic [IDX_W-1:0]         w_ptr_next;
    logic                     w_timeout;

    adc_scanner_uart_tx #(.TICKS_PER_CYCLE(TICKS_PER_CYCLE)) u_tx (
        .clk    (clock12MHz),
        .rst    (reset),
        .i_req  (r_send_req_q),
        .i_data (w_send_data),
        .o_done (w_tx_done),
        .o_tx   (serialOut)
    );

    adc_scanner_uart_rx #(.TICKS_PER_CYCLE(TICKS_PER_CYCLE)) u_rx (
        .clk     (clock12MHz),
        .rst     (reset),
        .i_ready (r_ready_q),
        .i_rx    (serialIn),
        .o_done  (w_rx_done),
        .o_data  (w_rx_data)
    );

    assign w_send_data = BASE_CMD + 8'(r_idx_q);
    assign w_ptr_next  = (r_idx_q == c_idx_last) ? '0 : r_idx_q + 1'b1;

    // Rotating a doubled mask by the pointer turns the wrap-around search
    // into a plain lowest-set-bit search.
    assign w_mask2 = {channelMask, channelMask};
    assign w_rot   = CHANNELS'(w_mask2 >> r_ptr_q);

    always_comb begin
        w_sel_found = 1'b0;
        w_sel_sum   = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!w_sel_found && w_rot[k]) begin
                w_sel_found = 1'b1;
                w_sel_sum   = int'(r_ptr_q) + k;
            end
        end
        if (w_sel_sum >= CHANNELS) w_sel_sum = w_sel_sum - CHANNELS;
        w_sel_idx = IDX_W'(w_sel_sum);
    end

    // Data beats the deadline when both land in the same cycle.
    assign w_timeout = ((r_state_q == S_RECV_LO) || (r_state_q == S_RECV_HI)) &&
                       !w_rx_done && (r_timer_q == c_timer_last);

    always_ff @(posedge clock12MHz) begin
        if (reset) begin
            r_state_q    <= S_IDLE;
            r_ptr_q      <= '0;
            r_idx_q      <= '0;
            r_send_req_q <= 1'b0;
            r_ready_q    <= 1'b0;
            r_timer_q    <= '0;
            r_lo_q       <= '0;
            r_values_q   <= '0;
            r_valid_q    <= '0;
            r_strobe_q   <= 1'b0;
            r_chan_q     <= '0;
            r_terr_q     <= 1'b0;
            r_tcount_q   <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_ptr_q      <= w_ptr_d;
            r_idx_q      <= w_idx_d;
            r_send_req_q <= w_send_req_d;
            r_ready_q    <= w_ready_d;
            r_timer_q    <= w_timer_d;
            r_lo_q       <= w_lo_d;
            r_values_q   <= w_values_d;
            r_valid_q    <= w_valid_d;
            r_strobe_q   <= w_strobe_d;
            r_chan_q     <= w_chan_d;
            r_terr_q     <= w_terr_d;
            r_tcount_q   <= w_tcount_d;
        end
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_ptr_d      = r_ptr_q;
        w_idx_d      = r_idx_q;
        w_send_req_d = r_send_req_q;
        w_ready_d    = r_ready_q;
        w_timer_d    = r_timer_q;
        w_lo_d       = r_lo_q;
        w_values_d   = r_values_q;
        w_valid_d    = r_valid_q;
        w_strobe_d   = 1'b0;
        w_chan_d     = r_chan_q;
        w_terr_d     = 1'b0;
        w_tcount_d   = r_tcount_q;

        case (r_state_q)
            S_IDLE: begin
                if (enable && (|channelMask)) w_state_d = S_SELECT;
            end
            S_SELECT: begin
                if (w_sel_found) begin
                    w_idx_d   = w_sel_idx;
                    w_state_d = S_SEND_WAIT;
                end else begin
                    w_state_d = S_IDLE;
                end
            end
            S_SEND_WAIT: begin
                if (!w_tx_done) w_state_d = S_SEND;
            end
            S_SEND: begin
                if (w_tx_done) begin
                    w_send_req_d = 1'b0;
                    w_ready_d    = 1'b1;
                    w_timer_d    = '0;
                    w_state_d    = S_RECV_LO;
                end else begin
                    w_send_req_d = 1'b1;
                end
            end
            S_RECV_LO: begin
                if (w_rx_done) begin
                    w_lo_d    = w_rx_data;
                    w_ready_d = 1'b0;
                    w_state_d = S_GAP;
                end else begin
                    w_timer_d = r_timer_q + 1'b1;
                end
            end
            S_GAP: begin
                if (!w_rx_done) begin
                    w_ready_d = 1'b1;
                    w_timer_d = '0;
                    w_state_d = S_RECV_HI;
                end
            end
            S_RECV_HI: begin
                if (w_rx_done) begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (r_idx_q == IDX_W'(i)) begin
                            w_values_d[i*10 +: 10] = {w_rx_data[1:0], r_lo_q};
                            w_valid_d[i]           = 1'b1;
                        end
                    end
                    w_strobe_d = 1'b1;
                    w_chan_d   = r_idx_q;
                    w_ready_d  = 1'b0;
                    w_ptr_d    = w_ptr_next;
                    w_state_d  = S_COMMIT;
                end else begin
                    w_timer_d = r_timer_q + 1'b1;
                end
            end
            S_COMMIT: begin
                if (!w_rx_done) w_state_d = S_IDLE;
            end
            default: w_state_d = S_IDLE;
        endcase

        if (w_timeout) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (r_idx_q == IDX_W'(i)) w_valid_d[i] = 1'b0;
            end
            w_ready_d  = 1'b0;
            w_terr_d   = 1'b1;
            w_chan_d   = r_idx_q;
            w_tcount_d = (r_tcount_q == 8'hFF) ? r_tcount_q : r_tcount_q + 1'b1;
            w_ptr_d    = w_ptr_next;
            w_timer_d  = '0;
            w_state_d  = S_IDLE;
        end
    end

    assign values        = r_values_q;
    assign valid         = r_valid_q;
    assign sampleStrobe  = r_strobe_q;
    assign sampleChannel = r_chan_q;
    assign timeoutError  = r_terr_q;
    assign timeoutCount  = r_tcount_q;
endmodule
`default_nettype wire

// File: tb/tb_adc_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_adc_scanner
//  Purpose  : Randomized bench for adc_scanner with an ADC responder and a
//             behavioural scan/commit/timeout model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_scanner;
    localparam int         CH   = 4;
    localparam int         TK   = 4;
    localparam int         TO   = 100;
    localparam logic [7:0] BASE = 8'hA1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [CH-1:0]     mask = '0;
    logic              serial_in = 1'b1;
    logic              serial_out;
    logic [10*CH-1:0]  values;
    logic [CH-1:0]     valid;
    logic              strobe;
    logic [1:0]        schan;
    logic              terr;
    logic [7:0]        tcount;

    adc_scanner #(
        .CHANNELS(CH), .TICKS_PER_CYCLE(TK), .BASE_CMD(BASE), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock12MHz(clk), .reset(reset), .enable(enable), .channelMask(mask),
        .serialIn(serial_in), .serialOut(serial_out), .values(values), .valid(valid),
        .sampleStrobe(strobe), .sampleChannel(schan), .timeoutError(terr),
        .timeoutCount(tcount)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; bit is_to; logic [9:0] v; } ev_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    longint     cyc     = 0;
    logic [9:0] m_val[CH];
    bit         m_valid[CH];
    int         m_cnt, m_ptr;
    ev_t        evq[$];
    logic [7:0] txlog[$];
    int         schan_log[$];
    int         n_commit = 0, n_to = 0;
    bit         silent[CH];
    bit         fixed_reply = 1'b0;
    logic [7:0] fix_lo = 8'h00, fix_hi = 8'h00;
    bit         adc_hi = 1'b0;
    longint     rdy_rise = 0;
    bit         rdy_prev = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < CH; i++) begin m_val[i] = '0; m_valid[i] = 1'b0; end
        m_cnt = 0; m_ptr = 0;
        evq.delete();
    endtask

    function automatic int next_ch();
        for (int k = 0; k < CH; k++) if (mask[(m_ptr + k) % CH]) return (m_ptr + k) % CH;
        return -1;
    endfunction

    // Compare process: consume expected events on strobes/timeouts, then
    // check the registered outputs against the model every cycle.
    always @(negedge clk) begin
        ev_t e;
        logic [10*CH-1:0] ev_vals;
        logic [CH-1:0]    ev_valid;
        cyc++;
        if (dut.r_ready_q && !rdy_prev) rdy_rise = cyc;
        rdy_prev = dut.r_ready_q;
        if (!reset) begin
            if (strobe || terr) begin
                if (evq.size() == 0) begin
                    check("unexpected_event", {strobe, terr}, 2'b00);
                end else begin
                    e = evq.pop_front();
                    check("event_kind", {strobe, terr}, e.is_to ? 2'b01 : 2'b10);
                    check("event_chan", schan, e.ch);
                    if (e.is_to) begin
                        m_valid[e.ch] = 1'b0;
                        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                        n_to++;
                        check("timeout_delay", cyc - rdy_rise, TO);
                    end else begin
                        m_val[e.ch]   = e.v;
                        m_valid[e.ch] = 1'b1;
                        n_commit++;
                        schan_log.push_back(int'(schan));
                    end
                    m_ptr = (e.ch + 1) % CH;
                end
            end
            for (int i = 0; i < CH; i++) begin
                ev_vals[i*10 +: 10] = m_val[i];
                ev_valid[i]         = m_valid[i];
            end
            check("values", values, ev_vals);
            check("valid", valid, ev_valid);
            check("timeout_count", tcount, m_cnt);
        end
    end

    task automatic send_byte(input logic [7:0] b, output bit ab);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        ab = 1'b0;
        for (int i = 0; i < 10; i++) begin
            serial_in = fr[i];
            for (int t = 0; t < TK; t++) begin
                @(negedge clk);
                if (reset) ab = 1'b1;
            end
            if (ab) begin serial_in = 1'b1; return; end
        end
        serial_in = 1'b1;
    endtask

    // ADC responder: decode each command byte and answer lo/hi after a
    // random turnaround, or stay silent for channels marked silent.
    initial begin
        logic [7:0] b, lo, hi;
        int  ch, ex;
        bit  ab;
        forever begin
            @(negedge clk);
            if (reset || serial_out !== 1'b0) continue;
            repeat (TK / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (TK) @(negedge clk);
                b[i] = serial_out;
            end
            repeat (TK) @(negedge clk);
            check("tx_stop_bit", serial_out, 1'b1);
            txlog.push_back(b);
            ex = next_ch();
            ch = (ex < 0) ? 0 : ex;
            check("tx_cmd", b, BASE + 8'(ch));
            if (silent[ch]) begin
                evq.push_back('{ch: ch, is_to: 1'b1, v: 10'd0});
            end else begin
                lo = fixed_reply ? fix_lo : 8'($urandom);
                hi = fixed_reply ? fix_hi :
                     (($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
                evq.push_back('{ch: ch, is_to: 1'b0, v: {hi[1:0], lo}});
                repeat (6 + $urandom_range(0, 15)) @(negedge clk);
                send_byte(lo, ab);
                if (!ab) begin
                    repeat (3 + $urandom_range(0, 12)) @(negedge clk);
                    adc_hi = 1'b1;
                    send_byte(hi, ab);
                    adc_hi = 1'b0;
                end
            end
        end
    end

    task automatic wait_events(input int n);
        int target;
        target = n_commit + n_to + n;
        for (int i = 0; i < 20000 && (n_commit + n_to) < target; i++) @(negedge clk);
        check("wait_events_timeout", (n_commit + n_to) >= target, 1'b1);
    endtask

    task automatic quiesce();
        int quiet, i;
        enable = 1'b0;
        quiet = 0;
        for (i = 0; i < 20000 && quiet < 300; i++) begin
            @(negedge clk);
            if (serial_out == 1'b0 || serial_in == 1'b0 || evq.size() != 0) quiet = 0;
            else quiet++;
        end
        check("quiesce_timeout", quiet >= 300, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        m_reset();
        txlog.delete();
        schan_log.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: actual cycle limit reached required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, txn, ready_bad, hi_bad, nc;
        for (int i = 0; i < CH; i++) silent[i] = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        check("rst_values", values, 0);
        check("rst_valid", valid, 0);
        check("rst_strobe", strobe, 0);
        check("rst_chan", schan, 0);
        check("rst_terr", terr, 0);
        check("rst_tcount", tcount, 0);
        check("rst_serial_out", serial_out, 1);
        reset = 1'b0;

        // Sparse mask: only channels 1 and 3 are ever requested.
        mask = 4'b1010; enable = 1'b1;
        wait_events(6);
        quiesce();
        bad = 0;
        for (int i = 0; i < txlog.size(); i++) begin
            if (txlog[i] != BASE + 8'(((i % 2) == 0) ? 1 : 3)) bad++;
        end
        check("mask1010_tx_sequence", bad, 0);
        check("mask1010_val0", values[9:0], 10'h000);
        check("mask1010_val2", values[29:20], 10'h000);
        check("mask1010_valid02", {valid[2], valid[0]}, 2'b00);

        // Fixed reply 0x34/0x02 on every channel.
        do_reset();
        mask = 4'b1111; fixed_reply = 1'b1; fix_lo = 8'h34; fix_hi = 8'h02; enable = 1'b1;
        for (int i = 0; i < 20000 && schan_log.size() < 4; i++) @(negedge clk);
        check("fixed_values", values, {4{10'h234}});
        check("fixed_valid", valid, 4'hF);
        for (int i = 0; i < 4; i++) begin
            check("fixed_strobe_chan", (schan_log.size() > i) ? schan_log[i] : -1, i);
            check("fixed_tx_byte", (txlog.size() > i) ? txlog[i] : 8'h00, BASE + 8'(i));
        end
        quiesce();

        // Random masks and random replies.
        fixed_reply = 1'b0;
        for (int r = 0; r < 6; r++) begin
            mask = 4'($urandom_range(1, 15));
            enable = 1'b1;
            wait_events(3 + $urandom_range(0, 4));
            quiesce();
        end

        // High byte 0xFF: only bits [1:0] reach the value.
        mask = 4'b0001; fixed_reply = 1'b1; fix_lo = 8'h5A; fix_hi = 8'hFF; enable = 1'b1;
        wait_events(1);
        check("hi_ff_value", values[9:0], 10'h35A);
        quiesce();
        fixed_reply = 1'b0;

        // Silent channel 2 with all channels enabled.
        do_reset();
        mask = 4'b1111; enable = 1'b1;
        wait_events(4);
        silent[2] = 1'b1;
        nc = n_to;
        for (int i = 0; i < 20000 && n_to == nc; i++) @(negedge clk);
        check("first_timeout_count", tcount, 8'd1);
        check("first_timeout_valid2", valid[2], 1'b0);
        txn = txlog.size();
        for (int i = 0; i < 20000 && txlog.size() <= txn; i++) @(negedge clk);
        check("after_timeout_tx", (txlog.size() > txn) ? txlog[txn] : 8'h00, BASE + 8'd3);
        wait_events(4);
        quiesce();

        // Saturation of the timeout counter.
        mask = 4'b0100; enable = 1'b1;
        nc = n_to;
        for (int i = 0; i < 80000 && n_to < nc + 300; i++) @(negedge clk);
        check("timeout_saturation", tcount, 8'd255);
        quiesce();
        silent[2] = 1'b0;

        // Reset while the high byte is arriving.
        mask = 4'b1111; enable = 1'b1;
        for (int i = 0; i < 20000 && !adc_hi; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_values", values, 0);
        check("midrst_valid", valid, 0);
        check("midrst_tcount", tcount, 0);
        check("midrst_strobe_terr", {strobe, terr}, 2'b00);
        check("midrst_chan", schan, 0);
        m_reset();
        txlog.delete();
        @(negedge clk);
        reset = 1'b0;
        ready_bad = 0;
        for (int i = 0; i < 5000 && txlog.size() == 0; i++) begin
            @(negedge clk);
            if (dut.r_ready_q && serial_out) ready_bad += (txlog.size() == 0) ? 1 : 0;
        end
        check("midrst_ready_before_send", ready_bad, 0);
        check("midrst_first_tx", (txlog.size() > 0) ? txlog[0] : 8'h00, BASE);
        quiesce();

        // Enable dropped while a command is on the wire.
        mask = 4'b1111; enable = 1'b1;
        for (int i = 0; i < 5000 && serial_out !== 1'b0; i++) @(negedge clk);
        enable = 1'b0;
        nc = n_commit;
        wait_events(1);
        check("drop_enable_commit", n_commit, nc + 1);
        txn = txlog.size();
        hi_bad = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (serial_out !== 1'b1) hi_bad++;
        end
        check("drop_enable_line_idle", hi_bad, 0);
        check("drop_enable_no_tx", txlog.size(), txn);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
